// File: rtl/dii_pkg.sv
// Shared definitions for the debug interconnect (DII) ring: flit and address
// widths, packet type codes, FLAGS flit field positions, the packetizer state
// encoding, and helpers that build header flits.
package dii_pkg;

  localparam int DII_FLIT_WIDTH = 16;
  localparam int DII_ADDR_WIDTH = 10;

  localparam logic [1:0] TYPE_REG   = 2'd0;
  localparam logic [1:0] TYPE_PLAIN = 2'd1;
  localparam logic [1:0] TYPE_EVENT = 2'd2;

  // FLAGS flit: type in [15:14], subtype in [13:10], rest zero
  localparam int FLAGS_TYPE_LSB    = 14;
  localparam int FLAGS_SUBTYPE_LSB = 10;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_DEST    = 3'd1,
    ST_SRC     = 3'd2,
    ST_FLAGS   = 3'd3,
    ST_PAYLOAD = 3'd4
  } pkt_state_t;

  function automatic logic [DII_FLIT_WIDTH-1:0] addr_flit(input logic [DII_ADDR_WIDTH-1:0] addr);
    addr_flit = {{(DII_FLIT_WIDTH-DII_ADDR_WIDTH){1'b0}}, addr};
  endfunction

  function automatic logic [DII_FLIT_WIDTH-1:0] flags_flit(input logic [1:0] typ,
                                                            input logic [3:0] subtype);
    flags_flit = '0;
    flags_flit[FLAGS_TYPE_LSB +: 2]    = typ;
    flags_flit[FLAGS_SUBTYPE_LSB +: 4] = subtype;
  endfunction

endpackage

// File: rtl/dii_channel.sv
// DII flit channel between a packet source (master) and a ring port (slave).
//   data  : 16-bit flit
//   last  : marks the final flit of a packet
//   valid : flit offered by master
//   ready : flit accepted by slave (transfer on valid & ready)
interface dii_channel;
  logic [15:0] data;
  logic        last;
  logic        valid;
  logic        ready;

  modport master (output data, output last, output valid, input ready);
  modport slave  (input data, input last, input valid, output ready);
endinterface

// File: rtl/osd_event_packetizer.sv
// Transmit end of a debug-ring port. Captures one module event and emits it
// as a DII packet: DEST, SRC, FLAGS header flits followed by payload flits.
// Ports:
//   clk, rst       clock; asynchronous active-high reset
//   id             own ring address (src field)
//   dest           destination address, sampled on capture
//   ev_type        packet type (dii_pkg TYPE_*)
//   ev_subtype     packet subtype
//   payload_words  payload flit count, saturated to MAX_PAYLOAD
//   payload        payload words, word k at [16k+:16], word 0 first
//   event_valid    event offered
//   event_ready    event accepted (IDLE and not in reset)
//   debug_out      DII master port towards the ring router local_in
//
// state      | meaning
// -----------+------------------------------------------------
// ST_IDLE    | no packet in flight, event_ready high
// ST_DEST    | destination flit presented
// ST_SRC     | source (own id) flit presented
// ST_FLAGS   | type/subtype flit presented, last if no payload
// ST_PAYLOAD | payload word r_idx presented
module osd_event_packetizer
  import dii_pkg::*;
#(
  parameter  int MAX_PKT_LEN = 8,
  localparam int MAX_PAYLOAD = MAX_PKT_LEN - 3,
  localparam int CW          = $clog2(MAX_PAYLOAD + 1)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [DII_ADDR_WIDTH-1:0]   id,
  input  logic [DII_ADDR_WIDTH-1:0]   dest,
  input  logic [1:0]                  ev_type,
  input  logic [3:0]                  ev_subtype,
  input  logic [CW-1:0]               payload_words,
  input  logic [16*MAX_PAYLOAD-1:0]   payload,
  input  logic                        event_valid,
  output logic                        event_ready,
  dii_channel.master                  debug_out
);

  localparam logic [CW-1:0] ONE     = CW'(1);
  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_PAYLOAD);

  pkt_state_t                  r_state;
  pkt_state_t                  w_state_nxt;
  logic [DII_ADDR_WIDTH-1:0]   r_id;
  logic [1:0]                  r_type;
  logic [3:0]                  r_subtype;
  logic [16*MAX_PAYLOAD-1:0]   r_payload;
  logic [CW-1:0]               r_cnt;
  logic [CW-1:0]               r_idx;
  logic [DII_FLIT_WIDTH-1:0]   r_data;
  logic                        r_last;
  logic                        r_valid;

  logic                        w_capture;
  logic                        w_xfer;
  logic [CW-1:0]               w_cnt_sat;
  logic [CW-1:0]               w_idx_inc;
  logic [CW-1:0]               w_word_idx;
  logic [DII_FLIT_WIDTH-1:0]   w_word;
  logic [DII_FLIT_WIDTH-1:0]   w_data_nxt;
  logic                        w_last_nxt;
  logic                        w_valid_nxt;
  logic [CW-1:0]               w_idx_nxt;

  assign event_ready = (r_state == ST_IDLE) & ~rst;
  assign w_capture   = (r_state == ST_IDLE) & event_valid;
  assign w_xfer      = r_valid & debug_out.ready;
  assign w_cnt_sat   = (payload_words > MAX_CNT) ? MAX_CNT : payload_words;
  assign w_idx_inc   = r_idx + ONE;

  assign debug_out.data  = r_data;
  assign debug_out.last  = r_last;
  assign debug_out.valid = r_valid;

  // Word that becomes visible after the current flit is accepted: word 0
  // when leaving FLAGS, otherwise the one after r_idx. Looping over the
  // legal indices keeps the select in range even past the final word.
  assign w_word_idx = (r_state == ST_FLAGS) ? '0 : w_idx_inc;

  always_comb begin
    w_word = '0;
    for (int k = 0; k < MAX_PAYLOAD; k++) begin
      if (w_word_idx == CW'(k)) begin
        w_word = r_payload[16*k +: 16];
      end
    end
  end

  // Output flops are loaded with the flit of the next state, so valid/data/
  // last come straight from registers and hold while ready is low.
  always_comb begin
    w_state_nxt = r_state;
    w_data_nxt  = r_data;
    w_last_nxt  = r_last;
    w_valid_nxt = r_valid;
    w_idx_nxt   = r_idx;
    unique case (r_state)
      ST_IDLE: begin
        w_valid_nxt = 1'b0;
        w_last_nxt  = 1'b0;
        w_data_nxt  = '0;
        if (w_capture) begin
          w_state_nxt = ST_DEST;
          w_valid_nxt = 1'b1;
          w_data_nxt  = addr_flit(dest);
          w_idx_nxt   = '0;
        end
      end
      ST_DEST: begin
        if (w_xfer) begin
          w_state_nxt = ST_SRC;
          w_data_nxt  = addr_flit(r_id);
        end
      end
      ST_SRC: begin
        if (w_xfer) begin
          w_state_nxt = ST_FLAGS;
          w_data_nxt  = flags_flit(r_type, r_subtype);
          w_last_nxt  = (r_cnt == '0);
        end
      end
      ST_FLAGS: begin
        if (w_xfer) begin
          if (r_cnt == '0) begin
            w_state_nxt = ST_IDLE;
            w_valid_nxt = 1'b0;
            w_last_nxt  = 1'b0;
            w_data_nxt  = '0;
          end else begin
            w_state_nxt = ST_PAYLOAD;
            w_data_nxt  = w_word;
            w_last_nxt  = (r_cnt == ONE);
            w_idx_nxt   = '0;
          end
        end
      end
      ST_PAYLOAD: begin
        if (w_xfer) begin
          if (r_idx == r_cnt - ONE) begin
            w_state_nxt = ST_IDLE;
            w_valid_nxt = 1'b0;
            w_last_nxt  = 1'b0;
            w_data_nxt  = '0;
          end else begin
            w_data_nxt  = w_word;
            w_last_nxt  = (w_idx_inc == r_cnt - ONE);
            w_idx_nxt   = w_idx_inc;
          end
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_valid_nxt = 1'b0;
        w_last_nxt  = 1'b0;
        w_data_nxt  = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_data    <= '0;
      r_last    <= 1'b0;
      r_valid   <= 1'b0;
      r_idx     <= '0;
      r_id      <= '0;
      r_type    <= '0;
      r_subtype <= '0;
      r_payload <= '0;
      r_cnt     <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_data  <= w_data_nxt;
      r_last  <= w_last_nxt;
      r_valid <= w_valid_nxt;
      r_idx   <= w_idx_nxt;
      if (w_capture) begin
        r_id      <= id;
        r_type    <= ev_type;
        r_subtype <= ev_subtype;
        r_payload <= payload;
        r_cnt     <= w_cnt_sat;
      end
    end
  end

endmodule

// File: tb/tb_osd_event_packetizer.sv
module tb_osd_event_packetizer;
  import dii_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [9:0]  id;
  logic [9:0]  dest;
  logic [1:0]  ev_type;
  logic [3:0]  ev_subtype;
  logic [2:0]  payload_words;
  logic [79:0] payload;
  logic        event_valid;
  logic        event_ready;

  dii_channel dbg ();

  osd_event_packetizer #(.MAX_PKT_LEN(8)) dut (
    .clk           (clk),
    .rst           (rst),
    .id            (id),
    .dest          (dest),
    .ev_type       (ev_type),
    .ev_subtype    (ev_subtype),
    .payload_words (payload_words),
    .payload       (payload),
    .event_valid   (event_valid),
    .event_ready   (event_ready),
    .debug_out     (dbg)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] data;
    logic        last;
  } flit_t;

  flit_t q[$];
  int n_cmp = 0;
  int n_err = 0;

  // ready driver: 0 = always 1, 1 = pattern 1,0,0,1,..., 2 = held low
  int ready_mode = 0;
  bit pat[4] = '{1'b1, 1'b0, 1'b0, 1'b1};

  initial begin
    int k;
    k = 0;
    dbg.ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0:       dbg.ready = 1'b1;
        1:       begin dbg.ready = pat[k % 4]; k++; end
        default: dbg.ready = 1'b0;
      endcase
    end
  end

  // Monitor: pops the scoreboard on every transfer, and checks that a
  // stalled flit is still presented unchanged the next cycle.
  initial begin
    logic        stalled;
    logic [15:0] h_data;
    logic        h_last;
    flit_t       exp_f;
    stalled = 1'b0;
    h_data  = '0;
    h_last  = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        stalled = 1'b0;
      end else begin
        if (stalled) begin
          n_cmp++;
          if (!(dbg.valid && dbg.data == h_data && dbg.last == h_last)) begin
            n_err++;
            $display("FAIL stall_hold: got valid=%0b data=%h last=%0b, need valid=1 data=%h last=%0b",
                     dbg.valid, dbg.data, dbg.last, h_data, h_last);
          end
        end
        if (dbg.valid && dbg.ready) begin
          n_cmp++;
          if (q.size() == 0) begin
            n_err++;
            $display("FAIL unexpected_flit: got data=%h last=%0b, need no flit", dbg.data, dbg.last);
          end else begin
            exp_f = q.pop_front();
            if (dbg.data !== exp_f.data || dbg.last !== exp_f.last) begin
              n_err++;
              $display("FAIL flit: got data=%h last=%0b, need data=%h last=%0b",
                       dbg.data, dbg.last, exp_f.data, exp_f.last);
            end
          end
          stalled = 1'b0;
        end else if (dbg.valid) begin
          stalled = 1'b1;
          h_data  = dbg.data;
          h_last  = dbg.last;
        end else begin
          stalled = 1'b0;
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] need);
    n_cmp++;
    if (got !== need) begin
      n_err++;
      $display("FAIL %s: got %h, need %h", name, got, need);
    end
  endtask

  task automatic push_pkt(input logic [9:0] d, input logic [1:0] t, input logic [3:0] s,
                          input logic [2:0] n, input logic [79:0] pl);
    int ns;
    flit_t f;
    ns = (n > 3'd5) ? 5 : int'(n);
    f.data = {6'h00, d};          f.last = 1'b0;       q.push_back(f);
    f.data = {6'h00, id};         f.last = 1'b0;       q.push_back(f);
    f.data = {t, s, 10'h000};     f.last = (ns == 0);  q.push_back(f);
    for (int i = 0; i < ns; i++) begin
      f.data = pl[16*i +: 16];
      f.last = (i == ns - 1);
      q.push_back(f);
    end
  endtask

  task automatic set_inputs(input logic [9:0] d, input logic [1:0] t, input logic [3:0] s,
                            input logic [2:0] n, input logic [79:0] pl);
    dest          = d;
    ev_type       = t;
    ev_subtype    = s;
    payload_words = n;
    payload       = pl;
  endtask

  // Waits (bounded) until the event is taken; returns at capture edge + 1.
  task automatic wait_capture(output int cycles);
    cycles = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      cycles++;
      if (event_ready) break;
    end
    if (!event_ready) begin
      n_cmp++;
      n_err++;
      $display("FAIL capture_timeout: got event_ready=0, need 1");
    end
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic [9:0] d, input logic [1:0] t, input logic [3:0] s,
                       input logic [2:0] n, input logic [79:0] pl);
    int c;
    set_inputs(d, t, s, n, pl);
    push_pkt(d, t, s, n, pl);
    event_valid = 1'b1;
    wait_capture(c);
    event_valid = 1'b0;
    set_inputs(10'h3FF, 2'd3, 4'hF, 3'd7, {5{16'hDEAD}});
  endtask

  task automatic wait_drain(input string name);
    int i;
    for (i = 0; i < 300; i++) begin
      @(negedge clk);
      if (q.size() == 0 && !dbg.valid) break;
    end
    n_cmp++;
    if (q.size() != 0 || dbg.valid) begin
      n_err++;
      $display("FAIL %s_drain: got %0d flits outstanding, need 0", name, q.size());
    end
  endtask

  initial begin
    int c;
    rst         = 1'b1;
    id          = 10'd1;
    event_valid = 1'b0;
    set_inputs('0, '0, '0, '0, '0);
    #2;
    check("rst_valid", 32'(dbg.valid), 32'd0);
    check("rst_last",  32'(dbg.last),  32'd0);
    check("rst_data",  32'(dbg.data),  32'd0);
    check("rst_event_ready", 32'(event_ready), 32'd0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("event_ready_after_rst", 32'(event_ready), 32'd1);

    // 1: basic event, 5 flits on consecutive cycles
    @(posedge clk); #1;
    offer(10'd0, TYPE_EVENT, 4'h3, 3'd2, {48'h0, 16'hCAFE, 16'hBEEF});
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("t1_valid_run", 32'(dbg.valid), 32'd1);
    end
    @(negedge clk);
    check("t1_idle_valid", 32'(dbg.valid), 32'd0);
    check("t1_idle_ready", 32'(event_ready), 32'd1);
    wait_drain("t1");

    // 2: no payload, last on FLAGS
    @(posedge clk); #1;
    offer(10'h155, TYPE_PLAIN, 4'h0, 3'd0, '0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("t2_valid_run", 32'(dbg.valid), 32'd1);
      check("t2_last", 32'(dbg.last), (i == 2) ? 32'd1 : 32'd0);
    end
    @(negedge clk);
    check("t2_event_ready", 32'(event_ready), 32'd1);
    wait_drain("t2");

    // 3: ready toggling during 5-word packet
    @(posedge clk); #1;
    ready_mode = 1;
    offer(10'h2A5, TYPE_REG, 4'hA, 3'd5,
          {16'h5555, 16'h4444, 16'h3333, 16'h2222, 16'h1111});
    wait_drain("t3");
    ready_mode = 0;

    // ready held low: block waits with valid high, no new event accepted
    @(posedge clk); #1;
    ready_mode = 2;
    offer(10'h0F0, TYPE_EVENT, 4'h1, 3'd1, {64'h0, 16'h0A0A});
    repeat (10) @(negedge clk);
    check("hold_valid", 32'(dbg.valid), 32'd1);
    check("hold_data", 32'(dbg.data), 32'h00F0);
    check("hold_event_ready", 32'(event_ready), 32'd0);
    ready_mode = 0;
    wait_drain("hold");

    // 4: back-to-back, event_valid held
    @(posedge clk); #1;
    set_inputs(10'h011, TYPE_PLAIN, 4'h2, 3'd0, '0);
    push_pkt(10'h011, TYPE_PLAIN, 4'h2, 3'd0, '0);
    push_pkt(10'h022, TYPE_EVENT, 4'h4, 3'd1, {64'h0, 16'h1234});
    event_valid = 1'b1;
    wait_capture(c);
    set_inputs(10'h022, TYPE_EVENT, 4'h4, 3'd1, {64'h0, 16'h1234});
    wait_capture(c);
    event_valid = 1'b0;
    check("t4_capture_gap", 32'(c), 32'd4);
    wait_drain("t4");

    // 5: saturation of payload_words=7 to 5 flits
    @(posedge clk); #1;
    offer(10'h3C3, TYPE_EVENT, 4'hF, 3'd7,
          {16'hA005, 16'hA004, 16'hA003, 16'hA002, 16'hA001});
    wait_drain("t5");

    // 6: reset while SRC flit is presented
    @(posedge clk); #1;
    offer(10'h077, TYPE_EVENT, 4'h5, 3'd2, {48'h0, 16'hB002, 16'hB001});
    @(posedge clk); #1;
    check("t6_src_data", 32'(dbg.data), 32'h0001);
    rst = 1'b1;
    #1;
    check("t6_rst_valid", 32'(dbg.valid), 32'd0);
    check("t6_rst_last",  32'(dbg.last),  32'd0);
    check("t6_rst_ready", 32'(event_ready), 32'd0);
    q.delete();
    id = 10'h3FF;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("t6_event_ready", 32'(event_ready), 32'd1);
    check("t6_idle_valid", 32'(dbg.valid), 32'd0);
    @(posedge clk); #1;
    offer(10'h200, TYPE_REG, 4'h6, 3'd1, {64'h0, 16'h7E57});
    @(negedge clk);
    check("t6_first_flit", 32'(dbg.data), 32'h0200);
    wait_drain("t6");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish, need finish");
    $fatal(1, "timeout");
  end

endmodule
